signed_divider: RTL
===================

# signed_divider

Sequential signed integer divider, the inverse of the registered multiplier. It accepts a two's-complement dividend and divisor through a ready/start handshake and runs restoring division on their magnitudes, one quotient bit per cycle. It then applies truncate-toward-zero sign correction and presents a registered quotient and remainder with a one-cycle done pulse. It sits in the datapath wherever a multiplier product is scaled back down.

## Interface
- WIDTH_N, 18: dividend and quotient width in bits, signed, ≥ 2.
- WIDTH_D, 8: divisor and remainder width in bits, signed, ≥ 2, ≤ WIDTH_N.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; operands are accepted on an edge where start and ready are both high.
- n  input  WIDTH_N  dividend, two's complement.
- d  input  WIDTH_D  divisor, two's complement.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when q and r are updated.
- q  output  WIDTH_N  quotient, held until the next done.
- r  output  WIDTH_D  remainder, held until the next done.
- dz  output  1  divide-by-zero flag, valid with done. Present only with SIGNED_DIVIDER_DZ_EN.

## Operation
- States:
  - IDLE → CALC on accept.
  - CALC → SIGN after WIDTH_N iterations.
  - SIGN → IDLE unconditionally.
- Accept edge:
  - Register |n| (WIDTH_N bits unsigned) and |d| (WIDTH_D bits unsigned).
  - Register sign_q = n[MSB] ^ d[MSB] and sign_r = n[MSB].
  - Register d_zero = (d == 0).
  - Clear the WIDTH_D+1-bit partial remainder and the iteration counter.
- CALC edge, MSB-first:
  - rem' = {rem, next dividend bit}.
  - If rem' ≥ |d|, subtract |d| and shift in quotient bit 1; otherwise restore and shift in 0.
- SIGN edge:
  - q ← sign_q ? −qmag : qmag.
  - r ← sign_r ? −rmag : rmag.
  - done ← 1.
- Semantics match Verilog signed / and %: the quotient truncates toward zero and the remainder takes the dividend's sign, with |r| < |d|.
- Overflow: n = −2^(WIDTH_N−1), d = −1 gives q = −2^(WIDTH_N−1) (two's-complement wrap) and r = 0. No flag.
- Divide by zero: q = all ones (−1), r = 0, regardless of n. Latency is unchanged.
- Operands are captured at accept; later changes to n and d have no effect.
- start while ready is low is ignored and not queued.

## Timing
- Reset values: state IDLE, ready 1, done 0, q 0, r 0, dz 0, internal registers 0.
- Accept at edge 0. CALC runs edges 1..WIDTH_N. SIGN is edge WIDTH_N+1, which updates q and r and asserts done.
- Latency from accept edge to done-visible: WIDTH_N+1 edges (19 at defaults).
- done is high for exactly one cycle, and ready is high in that same cycle. A start in the done cycle is accepted, giving a back-to-back throughput of one result per WIDTH_N+2 cycles.
- rst_n asserted mid-operation:
  - Abort immediately and return all outputs to their reset values.
  - No done for the aborted operation.
  - The first accept after deassertion proceeds normally.

## Configuration
- SIGNED_DIVIDER_DZ_EN defined: the dz port exists and equals the captured d_zero, updated on the SIGN edge with q and r.
- Not defined: the dz port and its register are absent.
- q and r behaviour, including the d == 0 forced result, is identical in both builds.

## Structure
- Shared package divider_pkg holds:
  - the state encoding localparams IDLE, CALC, SIGN;
  - a counter-width function clog2 used to size the iteration counter from WIDTH_N.
- One sub-module, div_abs: parameterized WIDTH, combinational two's-complement magnitude, unsigned output of WIDTH bits. It is instantiated for n and for d. Result negation is done inline.

## Test plan
- Basic: n=100, d=7 → q=14, r=2. done appears exactly 19 edges after accept; ready is low throughout CALC and SIGN.
- Signs:
  - n=−100, d=7 → q=−14, r=−2.
  - n=100, d=−7 → q=−14, r=2.
  - n=−100, d=−7 → q=14, r=−2.
- Extremes:
  - n=−131072, d=−1 → q=−131072, r=0.
  - n=−131072, d=−128 → q=1024, r=0.
  - n=131071, d=127 → q=1032, r=7.
- Zero divisor: n=55, d=0 → q=0x3FFFF, r=0, dz=1 with done. Then n=55, d=5 → dz=0, q=11.
- Handshake: hold start high with changing n and d during CALC; the in-flight result uses the accept-edge operands. A start in the done cycle is accepted, and its done follows 20 cycles after the previous done.
- Reset: assert rst_n at the 5th CALC cycle → q=0, r=0, done=0, ready=1. No stray done is produced. The next operation n=9, d=2 → q=4, r=1.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared state encoding and sizing helper for the sequential signed divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } state_t;

   // Bits needed to count 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int v = value - 1; v > 0; v = v >> 1) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/div_abs.sv
// Combinational two's-complement magnitude. The result is unsigned, so the most
// negative input maps to 2^(WIDTH-1) without overflowing.
module div_abs #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] mag
);

   assign mag = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per cycle,
// truncate-toward-zero sign fix-up. Define SIGNED_DIVIDER_DZ_EN to expose the dz flag.
module signed_divider
   import divider_pkg::*;
#(
   parameter int WIDTH_N = 18,
   parameter int WIDTH_D = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH_N-1:0] n,
   input  logic [WIDTH_D-1:0] d,
   output logic               ready,
   output logic               done,
   output logic [WIDTH_N-1:0] q,
`ifdef SIGNED_DIVIDER_DZ_EN
   output logic [WIDTH_D-1:0] r,
   output logic               dz
`else
   output logic [WIDTH_D-1:0] r
`endif
);

   localparam int CNT_W = clog2(WIDTH_N);

   state_t             state;
   logic [WIDTH_N-1:0] n_mag;
   logic [WIDTH_D-1:0] d_mag;
   logic [WIDTH_N-1:0] shreg;
   logic [WIDTH_D-1:0] dmag;
   logic [WIDTH_D:0]   rem;
   logic [CNT_W-1:0]   cnt;
   logic               sign_q;
   logic               sign_r;
   logic               d_zero;
   logic [WIDTH_D+1:0] rem_shift;
   logic [WIDTH_D+1:0] trial;
   logic               fits;

   div_abs #(.WIDTH(WIDTH_N)) u_abs_n (.value(n), .mag(n_mag));
   div_abs #(.WIDTH(WIDTH_D)) u_abs_d (.value(d), .mag(d_mag));

   // The partial remainder stays below |d|, so a borrow out of the trial subtraction means "restore".
   always_comb begin
      rem_shift = {rem, shreg[WIDTH_N-1]};
      trial     = rem_shift - {2'b00, dmag};
      fits      = ~trial[WIDTH_D+1];
   end

   // shreg starts as |n| and fills with quotient bits from the right as dividend bits leave on the left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ready  <= 1'b1;
         done   <= 1'b0;
         q      <= '0;
         r      <= '0;
         shreg  <= '0;
         dmag   <= '0;
         rem    <= '0;
         cnt    <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         d_zero <= 1'b0;
`ifdef SIGNED_DIVIDER_DZ_EN
         dz     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg  <= n_mag;
                  dmag   <= d_mag;
                  sign_q <= n[WIDTH_N-1] ^ d[WIDTH_D-1];
                  sign_r <= n[WIDTH_N-1];
                  d_zero <= (d == '0);
                  rem    <= '0;
                  cnt    <= '0;
                  ready  <= 1'b0;
                  state  <= CALC;
               end
            end
            CALC: begin
               rem   <= fits ? trial[WIDTH_D:0] : rem_shift[WIDTH_D:0];
               shreg <= {shreg[WIDTH_N-2:0], fits};
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH_N - 1)) state <= SIGN;
            end
            SIGN: begin
               // A zero divisor yields the fixed -1 / 0 result whatever the shifts produced.
               if (d_zero) begin
                  q <= '1;
                  r <= '0;
               end else begin
                  q <= sign_q ? -shreg : shreg;
                  r <= sign_r ? -rem[WIDTH_D-1:0] : rem[WIDTH_D-1:0];
               end
`ifdef SIGNED_DIVIDER_DZ_EN
               dz    <= d_zero;
`endif
               done  <= 1'b1;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
